// File: rtl/tpu_sequencer_if.sv
// ----------------------------------------------------------------------------
// tpu_sequencer_if
//   Bundles the control, instruction-memory and datapath signals that
//   tpu_sequencer exchanges with its surroundings.
//
//   master modport (the sequencer):
//     in : start, stall, instr_rdata
//     out: instr_addr, mem_addr, base_address, load_weight, load_input,
//          valid, busy, halted, error
//   slave modport (program memory, datapath and controller side):
//     the same signals with the directions reversed.
// ----------------------------------------------------------------------------
interface tpu_sequencer_if #(
    parameter int INSTR_W = 16,
    parameter int ADDR_W  = 13,
    parameter int PC_W    = 8
);
    logic               start;
    logic               stall;
    logic [PC_W-1:0]    instr_addr;
    logic [INSTR_W-1:0] instr_rdata;
    logic [ADDR_W-1:0]  mem_addr;
    logic [ADDR_W-1:0]  base_address;
    logic               load_weight;
    logic               load_input;
    logic               valid;
    logic               busy;
    logic               halted;
    logic               error;

    modport master (
        input  start, stall, instr_rdata,
        output instr_addr, mem_addr, base_address,
               load_weight, load_input, valid, busy, halted, error
    );

    modport slave (
        output start, stall, instr_rdata,
        input  instr_addr, mem_addr, base_address,
               load_weight, load_input, valid, busy, halted, error
    );
endinterface

// File: rtl/tpu_sequencer.sv
// ----------------------------------------------------------------------------
// tpu_sequencer
//   Program-driven sequencer for the systolic array. It fetches instructions
//   from a synchronous instruction memory (one cycle read latency) and decodes
//   them. LOAD_WEIGHT / LOAD_INPUT / COMPUTE become bursts of single-cycle
//   strobes, each paired with an incrementing memory address.
//
//   Ports:
//     clk    : clock, all state changes on the rising edge
//     reset  : synchronous, active-high
//     bus    : tpu_sequencer_if.master
//              start        - run program from pc 0 (honoured in IDLE/HALTED)
//              stall        - datapath back-pressure, freezes a burst
//              instr_addr   - instruction memory address (the pc)
//              instr_rdata  - instruction word, one cycle after instr_addr
//              mem_addr     - base_address + burst index (wraps)
//              base_address - operand of the last LOAD_ADDR
//              load_weight / load_input / valid - burst strobes
//              busy / halted / error - status
// ----------------------------------------------------------------------------
module tpu_sequencer #(
    parameter int INSTR_W = 16,
    parameter int OPC_W   = 3,
    parameter int ADDR_W  = 13,
    parameter int CNT_W   = 8,
    parameter int PC_W    = 8
) (
    input  logic            clk,
    input  logic            reset,
    tpu_sequencer_if.master bus
);

    localparam logic [OPC_W-1:0] OP_NOP       = OPC_W'(0);
    localparam logic [OPC_W-1:0] OP_LOAD_ADDR = OPC_W'(1);
    localparam logic [OPC_W-1:0] OP_LOAD_WGT  = OPC_W'(2);
    localparam logic [OPC_W-1:0] OP_LOAD_INP  = OPC_W'(3);
    localparam logic [OPC_W-1:0] OP_COMPUTE   = OPC_W'(4);
    localparam logic [OPC_W-1:0] OP_HALT      = OPC_W'(7);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_HALTED
    } state_t;

    // Only the fields that EXEC consumes are held from the decoded word.
    typedef struct packed {
        logic [OPC_W-1:0] opc;
        logic [CNT_W-1:0] len;
    } ir_t;

    state_t            state_q;
    logic [PC_W-1:0]   pc_q;
    ir_t               ir_q;
    logic [ADDR_W-1:0] base_q;
    logic [CNT_W-1:0]  idx_q;
    logic              error_q;
    logic              busy_q;
    logic              halted_q;

    // Fields of the word arriving from instruction memory (valid in DECODE).
    logic [OPC_W-1:0]  new_opc;
    logic [ADDR_W-1:0] new_operand;
    logic [CNT_W-1:0]  new_len;
    logic              exec_fire;
    logic              burst_last;

    assign new_opc     = bus.instr_rdata[INSTR_W-1 -: OPC_W];
    assign new_operand = bus.instr_rdata[ADDR_W-1:0];
    assign new_len     = new_operand[CNT_W-1:0];

    assign exec_fire  = (state_q == S_EXEC) && !bus.stall;
    // len is never zero in EXEC, so len-1 cannot underflow here.
    assign burst_last = (idx_q == ir_q.len - CNT_W'(1));

    // ------------------------------------------------------------------
    // Strobes: decoded from registered state and stall only, so nothing
    // from instr_rdata reaches the datapath strobes combinationally.
    // ------------------------------------------------------------------
    logic strb_weight;
    logic strb_input;
    logic strb_valid;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // so no path leaves it unassigned and no latch is inferred.
        strb_weight = 1'b0;
        strb_input  = 1'b0;
        strb_valid  = 1'b0;
        if (exec_fire) begin
            case (ir_q.opc)
                OP_LOAD_WGT: strb_weight = 1'b1;
                OP_LOAD_INP: strb_input  = 1'b1;
                OP_COMPUTE:  strb_valid  = 1'b1;
                default:     ;
            endcase
        end
    end

    assign bus.load_weight  = strb_weight;
    assign bus.load_input   = strb_input;
    assign bus.valid        = strb_valid;
    assign bus.instr_addr   = pc_q;
    assign bus.base_address = base_q;
    // Burst index is zero-extended; the add wraps modulo 2^ADDR_W.
    assign bus.mem_addr     = (state_q == S_EXEC) ? base_q + ADDR_W'(idx_q) : base_q;
    assign bus.busy         = busy_q;
    assign bus.halted       = halted_q;
    assign bus.error        = error_q;

    // ------------------------------------------------------------------
    // Control FSM. busy/halted are registered alongside every state change
    // so they always match the state register.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (reset) begin
            state_q  <= S_IDLE;
            pc_q     <= '0;
            ir_q     <= '0;
            base_q   <= '0;
            idx_q    <= '0;
            error_q  <= 1'b0;
            busy_q   <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_HALTED: begin
                    if (bus.start) begin
                        pc_q     <= '0;
                        error_q  <= 1'b0;
                        busy_q   <= 1'b1;
                        halted_q <= 1'b0;
                        state_q  <= S_FETCH;
                    end
                end

                // instr_addr is presented this cycle; the word returns next.
                S_FETCH: state_q <= S_DECODE;

                S_DECODE: begin
                    ir_q.opc <= new_opc;
                    ir_q.len <= new_len;
                    pc_q     <= pc_q + PC_W'(1);
                    case (new_opc)
                        OP_NOP: state_q <= S_FETCH;
                        OP_LOAD_ADDR: begin
                            base_q  <= new_operand;
                            state_q <= S_FETCH;
                        end
                        OP_LOAD_WGT, OP_LOAD_INP, OP_COMPUTE: begin
                            // A zero-length burst behaves as a NOP.
                            if (new_len != '0) begin
                                idx_q   <= '0;
                                state_q <= S_EXEC;
                            end else begin
                                state_q <= S_FETCH;
                            end
                        end
                        OP_HALT: begin
                            busy_q   <= 1'b0;
                            halted_q <= 1'b1;
                            state_q  <= S_HALTED;
                        end
                        default: begin
                            error_q  <= 1'b1;
                            busy_q   <= 1'b0;
                            halted_q <= 1'b1;
                            state_q  <= S_HALTED;
                        end
                    endcase
                end

                // Progress only on strobed cycles; stall freezes idx.
                S_EXEC: begin
                    if (!bus.stall) begin
                        if (burst_last) begin
                            idx_q   <= '0;
                            state_q <= S_FETCH;
                        end else begin
                            idx_q <= idx_q + CNT_W'(1);
                        end
                    end
                end

                default: begin
                    busy_q   <= 1'b0;
                    halted_q <= 1'b0;
                    state_q  <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tpu_sequencer.sv
// ----------------------------------------------------------------------------
// tb_tpu_sequencer
//   Self-checking bench for tpu_sequencer. A reference model walks the
//   program in instruction memory and queues the expected strobe
//   transactions (kind + address); a monitor pops and compares one entry
//   every cycle a strobe is seen. A second instance with PC_W=2 checks pc
//   wrap-around.
// ----------------------------------------------------------------------------
module tb_tpu_sequencer;

    localparam int INSTR_W = 16;
    localparam int OPC_W   = 3;
    localparam int ADDR_W  = 13;
    localparam int CNT_W   = 8;
    localparam int PC_W    = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    tpu_sequencer_if #(.INSTR_W(INSTR_W), .ADDR_W(ADDR_W), .PC_W(PC_W)) bus ();
    tpu_sequencer_if #(.INSTR_W(INSTR_W), .ADDR_W(ADDR_W), .PC_W(2))    bus2 ();

    tpu_sequencer #(
        .INSTR_W(INSTR_W), .OPC_W(OPC_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W), .PC_W(PC_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    tpu_sequencer #(
        .INSTR_W(INSTR_W), .OPC_W(OPC_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W), .PC_W(2)
    ) dut_pc2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    // Synchronous instruction memory with one cycle read latency.
    logic [INSTR_W-1:0] imem [2**PC_W];
    always @(posedge clk) bus.instr_rdata <= imem[bus.instr_addr];

    // ---------------------------------------------------------------- checks
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------- scoreboard
    typedef struct {
        logic [2:0]        strb;   // {load_weight, load_input, valid}
        logic [ADDR_W-1:0] addr;
    } txn_t;

    txn_t              exp_q[$];
    txn_t              mon_t;
    logic [ADDR_W-1:0] model_base = '0;

    always @(negedge clk) begin
        if (!reset && (bus.load_weight || bus.load_input || bus.valid)) begin
            check("strobe_gated_by_stall", {31'd0, bus.stall}, 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", {29'd0, bus.load_weight, bus.load_input, bus.valid}, 32'd0);
            end else begin
                mon_t = exp_q.pop_front();
                check("strobe_kind", {29'd0, bus.load_weight, bus.load_input, bus.valid}, {29'd0, mon_t.strb});
                check("strobe_addr", {19'd0, bus.mem_addr}, {19'd0, mon_t.addr});
            end
        end
    end

    // -------------------------------------------------------------- stall
    int   stall_mode   = 0;      // 0 none, 1 random, 2 manual
    logic stall_manual = 1'b0;

    initial begin
        bus.stall  = 1'b0;
        bus2.stall = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.stall = (stall_mode == 1) ? ($urandom_range(0, 99) < 35)
                      : (stall_mode == 2) ? stall_manual : 1'b0;
        end
    end

    // ---------------------------------------------------- reference model
    function automatic logic [INSTR_W-1:0] mk(input logic [2:0] op, input logic [12:0] opd);
        return {op, opd};
    endfunction

    // Walks the program as the architecture defines it: every instruction
    // costs fetch+decode (2 cycles) and a burst adds len strobe cycles.
    task automatic model_run(output int cycles, output logic err);
        int   pc = 0;
        logic [INSTR_W-1:0] w;
        int   op;
        int   len;
        txn_t t;
        cycles = 0;
        err    = 1'b0;
        for (int k = 0; k < 300; k++) begin
            w      = imem[pc];
            op     = int'(w[15:13]);
            len    = int'(w[7:0]);
            cycles += 2;
            pc     = (pc + 1) % (2**PC_W);
            if (op == 1) begin
                model_base = w[12:0];
            end else if (op >= 2 && op <= 4) begin
                for (int i = 0; i < len; i++) begin
                    t.strb = (op == 2) ? 3'b100 : (op == 3) ? 3'b010 : 3'b001;
                    t.addr = ADDR_W'(int'(model_base) + i);
                    exp_q.push_back(t);
                end
                cycles += len;
            end else if (op == 7) begin
                return;
            end else if (op == 5 || op == 6) begin
                err = 1'b1;
                return;
            end
        end
    endtask

    // ---------------------------------------------------------- drivers
    task automatic start_pulse();
        @(posedge clk); #1 bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
    endtask

    // Called just after the edge that accepted start. Halted becomes
    // visible exactly 'cycles' edges later, i.e. on negedge cycles+1.
    task automatic wait_halt(input int cycles, input logic err, input bit do_cyc);
        int cnt  = 0;
        bit done = 1'b0;
        while (!done && cnt < 2000) begin
            @(negedge clk);
            cnt++;
            if (bus.halted) done = 1'b1;
            else check("busy_while_running", {31'd0, bus.busy}, 32'd1);
        end
        check("halt_reached", {31'd0, done}, 32'd1);
        if (do_cyc) check("cycles_to_halt", cnt, cycles + 1);
        check("busy_when_halted", {31'd0, bus.busy}, 32'd0);
        check("error_flag", {31'd0, bus.error}, {31'd0, err});
        check("scoreboard_drained", exp_q.size(), 32'd0);
        check("base_address", {19'd0, bus.base_address}, {19'd0, model_base});
        check("mem_addr_idle", {19'd0, bus.mem_addr}, {19'd0, model_base});
    endtask

    task automatic run_program(input bit do_cyc);
        int   cyc;
        logic err;
        model_run(cyc, err);
        start_pulse();
        wait_halt(cyc, err, do_cyc);
    endtask

    task automatic clear_imem();
        for (int i = 0; i < 2**PC_W; i++) imem[i] = mk(3'd7, 13'd0);
    endtask

    task automatic gen_program();
        int p = 0;
        int n = $urandom_range(3, 8);
        clear_imem();
        for (int i = 0; i < n; i++) begin
            int         r   = $urandom_range(0, 99);
            logic [12:0] opd = 13'($urandom());
            if (r < 15) begin
                imem[p] = mk(3'd0, opd);
            end else if (r < 35) begin
                imem[p] = mk(3'd1, (r < 25) ? opd : 13'($urandom_range(8185, 8191)));
            end else if (r < 95) begin
                opd[7:0] = 8'($urandom_range(0, 6));
                imem[p]  = mk(3'($urandom_range(2, 4)), opd);
            end else begin
                imem[p] = mk((r < 97) ? 3'd5 : 3'd6, opd);
            end
            p++;
        end
        imem[p] = mk(3'd7, 13'd0);
    endtask

    // ---------------------------------------------------------- watchdog
    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1);
    end

    // -------------------------------------------------------------- main
    logic               seen;
    logic [2:0]         cnt_li;
    logic [5:0]         li_pat;
    logic [ADDR_W-1:0]  addr_pat [6];
    int                 cyc_m;
    logic               err_m;

    initial begin
        reset      = 1'b1;
        bus.start  = 1'b0;
        bus2.start = 1'b0;
        bus2.instr_rdata = mk(3'd0, 13'd0);   // every word is a NOP
        clear_imem();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_strobes", {29'd0, bus.load_weight, bus.load_input, bus.valid}, 32'd0);
        check("reset_status", {29'd0, bus.busy, bus.halted, bus.error}, 32'd0);
        check("reset_addrs", {bus.instr_addr, bus.mem_addr, bus.base_address}, 32'd0);
        @(posedge clk); #1 reset = 1'b0;

        // LOAD_ADDR 0x100, LOAD_WEIGHT 3, HALT
        clear_imem();
        imem[0] = mk(3'd1, 13'h100);
        imem[1] = mk(3'd2, 13'd3);
        imem[2] = mk(3'd7, 13'd0);
        run_program(1'b1);

        // LOAD_INPUT 4 with stall on the 2nd and 3rd EXEC cycles
        clear_imem();
        imem[0] = mk(3'd1, 13'h200);
        imem[1] = mk(3'd3, 13'd4);
        imem[2] = mk(3'd7, 13'd0);
        stall_mode   = 2;
        stall_manual = 1'b0;
        model_run(cyc_m, err_m);
        start_pulse();
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = bus.load_input;
        end
        check("stall_first_strobe_seen", {31'd0, seen}, 32'd1);
        li_pat[0]   = bus.load_input;
        addr_pat[0] = bus.mem_addr;
        stall_manual = 1'b1;
        for (int c = 1; c < 6; c++) begin
            @(negedge clk);
            li_pat[c]   = bus.load_input;
            addr_pat[c] = bus.mem_addr;
            if (c == 2) stall_manual = 1'b0;
        end
        check("stall_strobe_pattern", {26'd0, li_pat}, 32'b111001);
        check("stall_addr_1", {19'd0, addr_pat[1]}, 32'h201);
        check("stall_addr_2", {19'd0, addr_pat[2]}, 32'h201);
        check("stall_addr_3", {19'd0, addr_pat[3]}, 32'h201);
        check("stall_addr_5", {19'd0, addr_pat[5]}, 32'h203);
        cnt_li = 3'(li_pat[0] + li_pat[1] + li_pat[2] + li_pat[3] + li_pat[4] + li_pat[5]);
        check("stall_strobe_count", {29'd0, cnt_li}, 32'd4);
        wait_halt(cyc_m, err_m, 1'b0);
        stall_mode = 0;

        // COMPUTE 0, NOP, COMPUTE 2, HALT
        clear_imem();
        imem[0] = mk(3'd4, 13'd0);
        imem[1] = mk(3'd0, 13'd0);
        imem[2] = mk(3'd4, 13'd2);
        imem[3] = mk(3'd7, 13'd0);
        run_program(1'b1);

        // Illegal opcode 101, then a rerun that first clears error
        clear_imem();
        imem[0] = 16'hA000;
        run_program(1'b1);
        model_run(cyc_m, err_m);
        start_pulse();
        @(negedge clk);
        check("rerun_error_cleared", {31'd0, bus.error}, 32'd0);
        check("rerun_pc_zero", {24'd0, bus.instr_addr}, 32'd0);
        wait_halt(cyc_m, err_m, 1'b0);

        // mem_addr wrap: base 8190, LOAD_WEIGHT 4
        clear_imem();
        imem[0] = mk(3'd1, 13'd8190);
        imem[1] = mk(3'd2, 13'd4);
        imem[2] = mk(3'd7, 13'd0);
        run_program(1'b1);

        // reset on the 2nd cycle of LOAD_WEIGHT 10
        clear_imem();
        imem[0] = mk(3'd1, 13'h40);
        imem[1] = mk(3'd2, 13'd10);
        imem[2] = mk(3'd7, 13'd0);
        model_run(cyc_m, err_m);
        start_pulse();
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = bus.load_weight;
        end
        check("reset_burst_started", {31'd0, seen}, 32'd1);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midreset_strobes", {29'd0, bus.load_weight, bus.load_input, bus.valid}, 32'd0);
        check("midreset_status", {29'd0, bus.busy, bus.halted, bus.error}, 32'd0);
        check("midreset_addrs", {bus.instr_addr, bus.mem_addr, bus.base_address}, 32'd0);
        exp_q.delete();
        model_base = '0;
        @(posedge clk); #1 reset = 1'b0;
        run_program(1'b1);

        // PC_W=2 instance running NOPs with no HALT: pc wraps 3 -> 0
        @(posedge clk); #1 bus2.start = 1'b1;
        @(posedge clk); #1 bus2.start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("pc_wrap", {30'd0, bus2.instr_addr}, 32'((i / 2) % 4));
        end

        // Randomized programs, alternating stall-free and random stall
        for (int r = 0; r < 8; r++) begin
            gen_program();
            stall_mode = r % 2;
            run_program(stall_mode == 0);
        end
        stall_mode = 0;

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
